// File: rtl/soc_pio_input_irq_if.sv
// rtl/soc_pio_input_irq_if.sv - Avalon-MM slave bus bundle for soc_pio_input_irq
// Signals: address[1:0], chipselect, write_n (active low), writedata[31:0],
// readdata[31:0] (registered by the slave, read latency 1).
interface soc_pio_input_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_pio_input_irq.sv
// rtl/soc_pio_input_irq.sv - input PIO with synchroniser, edge capture and level irq
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   bus (slave)      register access; 0 DATA (ro), 1 MASK (rw), 2 EDGE (w1c), 3 reserved
//   in_port[WIDTH]   asynchronous external inputs
//   irq              OR of (capture & mask), active high
// Optional feature: SOC_PIO_DEBOUNCE_EN adds a per-bit debounce filter of
// DEBOUNCE_CYCLES stable cycles between the synchroniser and the edge detector.
module soc_pio_input_irq #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    soc_pio_input_irq_if.slave    bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_v;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] capture_q;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] clear_w;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end

    assign sync_v = sync_q[SYNC_STAGES-1];

`ifdef SOC_PIO_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0]  db_cnt [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // The counter only runs while a bit disagrees with its filtered value;
    // any return to agreement restarts it, so short glitches never land.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_v[i] == filt_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt_q[i] <= sync_v[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign filtered = filt_q;
`else
    assign filtered = sync_v;
`endif

    // Edge detection stays off until the synchroniser has flushed its reset
    // zeros, so inputs already high at reset do not look like rising edges.
    assign armed = (arm_cnt == ARM_W'(ARM_MAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       detect = filtered & ~prev_q;
            1:       detect = ~filtered & prev_q;
            default: detect = filtered ^ prev_q;
        endcase
        edge_set = armed ? detect : '0;
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata_w      = bus.writedata[WIDTH-1:0];
    assign clear_w      = (wr_en && bus.address == 2'd2) ? wdata_w : '0;
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            mask_q    <= '0;
            capture_q <= '0;
        end else begin
            prev_q <= filtered;
            if (wr_en && bus.address == 2'd1) mask_q <= wdata_w;
            // Applying the set after the clear makes a same-cycle edge win.
            capture_q <= (capture_q & ~clear_w) | edge_set;
        end
    end

    always_comb begin
        rd_word = '0;
        case (bus.address)
            2'd0:    rd_word[WIDTH-1:0] = filtered;
            2'd1:    rd_word[WIDTH-1:0] = mask_q;
            2'd2:    rd_word[WIDTH-1:0] = capture_q;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_word;
    end

    assign irq = |(capture_q & mask_q);
endmodule

// File: tb/tb_soc_pio_input_irq.sv
// tb/tb_soc_pio_input_irq.sv - scoreboard bench for soc_pio_input_irq
module tb_soc_pio_input_irq;
    localparam int SYNC = 2;
`ifdef SOC_PIO_DEBOUNCE_EN
    localparam int LAT = SYNC + 8;
    localparam logic [15:0] IN0_INIT = 16'h0000;
`else
    localparam int LAT = SYNC;
    localparam logic [15:0] IN0_INIT = 16'hFFFF;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  cs;
    logic [15:0] in0;
    logic [4:0]  in1;
    logic [7:0]  in2;
    logic        irq0, irq1, irq2;
    logic [31:0] rd [3];

    soc_pio_input_irq_if bus0 ();
    soc_pio_input_irq_if bus1 ();
    soc_pio_input_irq_if bus2 ();

    assign bus0.address = address;  assign bus0.chipselect = cs[0];
    assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
    assign bus1.address = address;  assign bus1.chipselect = cs[1];
    assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
    assign bus2.address = address;  assign bus2.chipselect = cs[2];
    assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;
    assign rd[0] = bus0.readdata;
    assign rd[1] = bus1.readdata;
    assign rd[2] = bus2.readdata;

    soc_pio_input_irq #(.WIDTH(16), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in0), .irq(irq0));
    soc_pio_input_irq #(.WIDTH(5), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(in1), .irq(irq1));
    soc_pio_input_irq #(.WIDTH(8), .SYNC_STAGES(SYNC), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(8)) u2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in2), .irq(irq2));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        int          unit;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t sb[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Chipselect stays low: readdata must follow address regardless.
    task automatic bus_read(input int unit, input logic [1:0] addr, input logic [31:0] exp,
                            input string tag);
        rd_exp_t e;
        e.tag = tag; e.unit = unit; e.exp = exp;
        sb.push_back(e);
        address = addr;
        cs      = 3'b000;
        write_n = 1'b1;
        tick(1);
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, rd[e.unit], e.exp);
        end
    endtask

    task automatic bus_write(input int unit, input logic [1:0] addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write_n   = 1'b0;
        cs        = 3'(1 << unit);
        tick(1);
        cs        = 3'b000;
        write_n   = 1'b1;
    endtask

    logic [2:0] seen;

    initial begin
        reset_n = 1'b0; cs = 3'b000; write_n = 1'b1; address = 2'd0; writedata = '0;
        in0 = IN0_INIT; in1 = '0; in2 = '0;
        tick(3);
        check_eq("rst_rd0", rd[0], 32'h0);
        check_eq("rst_irq", {29'h0, irq2, irq1, irq0}, 32'h0);

        // Inputs high at reset must not capture during arming.
        reset_n = 1'b1;
        bus_write(0, 2'd1, 32'h0000_FFFF);
        seen = '0;
        repeat (20) begin
            tick(1);
            seen |= {irq2, irq1, irq0};
        end
        check_eq("arm_irq", {29'h0, seen}, 32'h0);
        bus_read(0, 2'd0, {16'h0, IN0_INIT}, "arm_data0");
        bus_read(0, 2'd2, 32'h0, "arm_edge0");

        // Rising-edge capture on bit 3 and irq timing.
        bus_write(0, 2'd1, 32'h0000_0008);
        in0 = 16'h0000;
        tick(LAT + 4);
        bus_read(0, 2'd2, 32'h0, "fall_ignored0");
        in0[3] = 1'b1;
        tick(LAT);
        check_eq("irq_early", {31'h0, irq0}, 32'h0);
        tick(1);
        check_eq("irq_on", {31'h0, irq0}, 32'h1);
        bus_read(0, 2'd2, 32'h0000_0008, "edge_b3");
        bus_read(0, 2'd0, 32'h0000_0008, "data_b3");

        // Write-1-to-clear, then set-wins collision.
        bus_write(0, 2'd2, 32'h0000_0008);
        check_eq("irq_clr", {31'h0, irq0}, 32'h0);
        bus_read(0, 2'd2, 32'h0, "edge_clr");
        in0[3] = 1'b0;
        tick(LAT + 4);
        in0[3] = 1'b1;
        tick(LAT);
        bus_write(0, 2'd2, 32'h0000_0008);
        check_eq("irq_setwins", {31'h0, irq0}, 32'h1);
        bus_read(0, 2'd2, 32'h0000_0008, "edge_setwins");
        bus_write(0, 2'd1, 32'h0);
        check_eq("irq_masked", {31'h0, irq0}, 32'h0);
        bus_read(0, 2'd2, 32'h0000_0008, "edge_masked");

        // Asynchronous reset mid-operation.
        bus_write(0, 2'd1, 32'h0000_0008);
        check_eq("irq_premrst", {31'h0, irq0}, 32'h1);
        in0 = in0 & IN0_INIT;
        reset_n = 1'b0;
        #1;
        check_eq("mrst_irq", {31'h0, irq0}, 32'h0);
        check_eq("mrst_rd0", rd[0], 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(20);
        bus_read(0, 2'd2, 32'h0, "mrst_edge");
        bus_read(0, 2'd1, 32'h0, "mrst_mask");

        // Falling-only unit.
        in2[0] = 1'b1;
        tick(LAT + 4);
        bus_read(2, 2'd2, 32'h0, "fall_rise_ign");
        in2[0] = 1'b0;
        tick(LAT + 4);
        bus_read(2, 2'd2, 32'h0000_0001, "fall_set");
        check_eq("irq2_nomask", {31'h0, irq2}, 32'h0);

        // Any-edge unit.
        in1[0] = 1'b1;
        tick(LAT + 4);
        bus_read(1, 2'd2, 32'h0000_0001, "any_rise");
        bus_write(1, 2'd2, 32'h0000_0001);
        bus_read(1, 2'd2, 32'h0, "any_clr");
        in1[0] = 1'b0;
        tick(LAT + 4);
        bus_read(1, 2'd2, 32'h0000_0001, "any_fall");

        // Width masking and reserved address.
        bus_write(1, 2'd1, 32'hFFFF_FFFF);
        bus_read(1, 2'd1, 32'h0000_001F, "mask_w5");
        check_eq("irq1_on", {31'h0, irq1}, 32'h1);
        bus_read(1, 2'd3, 32'h0, "rsv_rd");
        bus_write(1, 2'd3, 32'hFFFF_FFFF);
        bus_read(1, 2'd3, 32'h0, "rsv_wr");
        bus_read(1, 2'd1, 32'h0000_001F, "mask_keep");
        in1 = 5'h1F;
        tick(LAT + 4);
        bus_write(1, 2'd0, 32'h0);
        bus_read(1, 2'd0, 32'h0000_001F, "data_w5");
        bus_write(1, 2'd2, 32'hFFFF_FFE0);
        bus_read(1, 2'd2, 32'h0000_001F, "edge_hi_ign");
        bus_write(1, 2'd2, 32'hFFFF_FFFF);
        bus_read(1, 2'd2, 32'h0, "edge_w5_clr");
        check_eq("irq1_off", {31'h0, irq1}, 32'h0);

`ifdef SOC_PIO_DEBOUNCE_EN
        bus_write(0, 2'd1, 32'h0000_0002);
        in0[1] = 1'b1;
        tick(5);
        in0[1] = 1'b0;
        tick(30);
        bus_read(0, 2'd0, {16'h0, in0}, "db_glitch_data");
        bus_read(0, 2'd2, 32'h0, "db_glitch_edge");
        address = 2'd0;
        in0[1] = 1'b1;
        tick(LAT);
        check_eq("db_irq_early", {31'h0, irq0}, 32'h0);
        check_eq("db_data_early", rd[0] & 32'h2, 32'h0);
        tick(1);
        check_eq("db_irq_on", {31'h0, irq0}, 32'h1);
        check_eq("db_data_on", rd[0] & 32'h2, 32'h2);
        tick(20 - LAT - 1);
        in0[1] = 1'b0;
        tick(30);
        bus_read(0, 2'd2, 32'h0000_0002, "db_edge");
        bus_read(0, 2'd0, {16'h0, in0}, "db_data_back");
`endif

        if (sb.size() != 0) check_eq("sb_leftover", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
